// File: rtl/seq_pkg.sv
// Shared definitions for the mod-3 detection path:
// serializer FSM states and default word width.
package seq_pkg;

    localparam int SEQ_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder, MSB first, with start-of-number
// and end-of-word markers for the downstream mod-3 detector.
module seq_bit_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sof,
    input  logic             ser_en,
    output logic             ser_bit,
    output logic             ser_vld,
    output logic             ser_sof,
    output logic             ser_eow,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [WIDTH-1:0] r_shift;
    logic             r_vld;
    logic             r_sof;
    logic             r_eow;
    logic             w_last;
    logic             w_rdy;
    logic             w_load;
    logic             w_shift;

    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_last    = (r_cnt == LAST);

    // Ready never looks at in_vld; only state, count and stall.
    always_comb begin
        w_state_nxt = r_state;
        w_rdy       = 1'b0;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_rdy = 1'b1;
                if (in_vld) begin
                    w_load      = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (ser_en) begin
                    if (w_last) begin
                        w_rdy = 1'b1;
                        if (in_vld) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_shift = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_vld   <= 1'b0;
            r_sof   <= 1'b0;
            r_eow   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_shift <= in_data;
                r_cnt   <= '0;
                r_vld   <= 1'b1;
                r_sof   <= in_sof;
                r_eow   <= 1'b0;
            end else if (w_shift) begin
                r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                r_cnt   <= w_cnt_inc;
                r_sof   <= 1'b0;
                r_eow   <= (w_cnt_inc == LAST);
            end else if (w_state_nxt == IDLE) begin
                r_shift <= '0;
                r_cnt   <= '0;
                r_vld   <= 1'b0;
                r_sof   <= 1'b0;
                r_eow   <= 1'b0;
            end
        end
    end

    assign in_rdy  = w_rdy & ~rst;
    assign ser_bit = r_shift[WIDTH-1];
    assign ser_vld = r_vld;
    assign ser_sof = r_sof;
    assign ser_eow = r_eow;
    assign busy    = (r_state == SHIFT);

endmodule
